// File: rtl/intpol2_d4_pkg.sv
// Shared constants for the interpolator input-FIFO writer: state encoding,
// default sample width and skid depth.
package intpol2_d4_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int SKID_DEPTH     = 2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/intpol2_d4_skid.sv
// Two-entry in-order skid buffer with valid/ready on both sides and an
// occupancy count. A push and a pop in the same cycle leave occupancy unchanged.
module intpol2_d4_skid #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [1:0]   occupancy
);

  logic [W-1:0] mem0;
  logic [W-1:0] mem1;
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;
  logic         push;
  logic         pop;

  assign in_ready  = (count < 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_data  = rd_ptr ? mem1 : mem0;
  assign occupancy = count;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem0   <= '0;
      mem1   <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        if (wr_ptr) mem1 <= in_data;
        else        mem0 <= in_data;
        wr_ptr <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      if (push && !pop)      count <= count + 2'd1;
      else if (!push && pop) count <= count - 2'd1;
    end
  end

endmodule

// File: rtl/intpol2_d4_in_fifo_wr.sv
// Frame-based writer into the interpolator input FIFO: accepts ilen samples
// upstream, passes them through a 2-entry skid and writes them while the FIFO has room.
module intpol2_d4_in_fifo_wr
  import intpol2_d4_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  start,
  input  logic [DATA_WIDTH:0]   ilen,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  Afull,
  input  logic                  Full,
  output logic                  Write_Enable,
  output logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  busy,
  output logic                  frame_done,
  output logic [DATA_WIDTH:0]   wr_cnt,
  output logic [1:0]            fsm_state
);

  localparam int CW = DATA_WIDTH + 1;

  logic [1:0]    state;
  logic [CW-1:0] ilen_q;
  logic [CW-1:0] acc_cnt;
  logic [CW-1:0] acc_next;
  logic [CW-1:0] wr_cnt_q;
  logic          soft_rst;
  logic          handshake;
  logic          skid_in_ready;
  logic          skid_out_valid;
  logic          fifo_room;
  logic [1:0]    occ;

  // Handshakes: a transfer happens on a side exactly when valid && ready in the
  // same cycle; upstream s_valid may stay high regardless of s_ready.
  assign soft_rst     = rst | clear;
  assign s_ready      = (state == ST_LOAD) && skid_in_ready && (acc_cnt < ilen_q);
  assign handshake    = s_valid & s_ready;
  assign acc_next     = acc_cnt + CW'(1);
  assign fifo_room    = ~Afull & ~Full;
  assign Write_Enable = skid_out_valid & fifo_room;
  assign busy         = (state == ST_LOAD) || (state == ST_FLUSH);
  assign frame_done   = (state == ST_DONE);
  assign wr_cnt       = wr_cnt_q;
  assign fsm_state    = state;

  intpol2_d4_skid #(.W(DATA_WIDTH)) u_skid (
    .clk       (clk),
    .rst       (soft_rst),
    .in_data   (s_data),
    .in_valid  (handshake),
    .in_ready  (skid_in_ready),
    .out_data  (fifo_data),
    .out_valid (skid_out_valid),
    .out_ready (fifo_room),
    .occupancy (occ)
  );

  always_ff @(posedge clk) begin
    if (soft_rst) begin
      state    <= ST_IDLE;
      ilen_q   <= '0;
      acc_cnt  <= '0;
      wr_cnt_q <= '0;
    end else begin
      if (Write_Enable && (wr_cnt_q < ilen_q)) wr_cnt_q <= wr_cnt_q + CW'(1);
      case (state)
        ST_IDLE: begin
          if (start) begin
            ilen_q   <= ilen;
            acc_cnt  <= '0;
            wr_cnt_q <= '0;
            state    <= (ilen == '0) ? ST_DONE : ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (handshake) begin
            acc_cnt <= acc_next;
            if (acc_next == ilen_q) state <= ST_FLUSH;
          end
        end
        // Leave as the last entry drains so frame_done follows the final write directly.
        ST_FLUSH: begin
          if ((occ == 2'd0) || ((occ == 2'd1) && Write_Enable)) state <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_intpol2_d4_in_fifo_wr.sv
// Directed bench for the input-FIFO writer: hand-derived per-cycle expectations
// plus an in-order scoreboard on every FIFO write.
module tb_intpol2_d4_in_fifo_wr;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, clear, start, s_valid, Afull, Full;
  logic [W:0]   ilen;
  logic [W-1:0] s_data;
  logic         s_ready, Write_Enable, busy, frame_done;
  logic [W-1:0] fifo_data;
  logic [W:0]   wr_cnt;
  logic [1:0]   fsm_state;

  int           checks   = 0;
  int           failures = 0;
  int           wr_seen  = 0;
  logic [W-1:0] next_data;
  logic [W-1:0] base;
  logic [W-1:0] exp_q[$];
  logic [15:0]  rdy_mask;
  logic [15:0]  we_mask;

  intpol2_d4_in_fifo_wr #(.DATA_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .clear(clear), .start(start), .ilen(ilen),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .Afull(Afull), .Full(Full), .Write_Enable(Write_Enable),
    .fifo_data(fifo_data), .busy(busy), .frame_done(frame_done),
    .wr_cnt(wr_cnt), .fsm_state(fsm_state)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: pop before push, a sample cannot be written in its accept cycle
  always @(negedge clk) begin
    if (Write_Enable) begin
      wr_seen++;
      check("we_while_full", Full, 1'b0);
      check("sb_nonempty", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) check("sb_data", fifo_data, exp_q.pop_front());
    end
    if (s_valid && s_ready) exp_q.push_back(s_data);
  end

  // driver tasks
  task automatic drive(input logic v);
    @(posedge clk); #1;
    start   = 1'b0;
    s_valid = v;
    s_data  = next_data;
  endtask

  task automatic accept_note();
    if (s_valid && s_ready) next_data = next_data + 1;
  endtask

  task automatic start_frame(input int len);
    @(posedge clk); #1;
    start   = 1'b1;
    ilen    = (W+1)'(len);
    s_valid = 1'b0;
    wr_seen = 0;
    @(negedge clk);
  endtask

  task automatic finish_frame(input int len, input logic gaps, input string tag);
    logic done;
    done = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      drive(gaps ? 1'($urandom_range(0, 1)) : 1'b1);
      if (gaps) Afull = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      accept_note();
      if (frame_done) begin
        done = 1'b1;
        check({tag, "_wr_cnt"}, wr_cnt, 64'(len));
        check({tag, "_writes"}, wr_seen, 64'(len));
        check({tag, "_sb_empty"}, exp_q.size(), 0);
      end
    end
    check({tag, "_done_seen"}, done, 1'b1);
    drive(1'b0);
    Afull = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; start = 1'b0; s_valid = 1'b0;
    Afull = 1'b0; Full = 1'b0; ilen = '0; s_data = '0;
    next_data = 32'h1000_0000;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_s_ready", s_ready, 1'b0);
    check("rst_we", Write_Enable, 1'b0);
    check("rst_fifo_data", fifo_data, 0);
    check("rst_busy", busy, 1'b0);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_wr_cnt", wr_cnt, 0);
    check("rst_state", fsm_state, 2'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // ilen=8, continuous valid: accepts k0..7, writes k1..8, done at k9
    base = next_data;
    start_frame(8);
    check("t1_busy_at_start", busy, 1'b0);
    for (int k = 0; k <= 10; k++) begin
      drive(1'b1);
      @(negedge clk);
      check("t1_s_ready", s_ready, k <= 7);
      check("t1_we", Write_Enable, (k >= 1) && (k <= 8));
      check("t1_frame_done", frame_done, k == 9);
      check("t1_busy", busy, k <= 8);
      if (k == 1) check("t1_first_data", fifo_data, base);
      if (k == 9) begin
        check("t1_wr_cnt", wr_cnt, 8);
        check("t1_writes", wr_seen, 8);
      end
      accept_note();
    end
    drive(1'b0);

    // ilen=6, Afull over frame cycles 3..7
    base     = next_data;
    rdy_mask = 16'h060F;
    we_mask  = 16'h0F06;
    start_frame(6);
    for (int k = 0; k <= 13; k++) begin
      drive(1'b1);
      Afull = (k >= 3) && (k <= 7);
      @(negedge clk);
      check("t2_s_ready", s_ready, rdy_mask[k]);
      check("t2_we", Write_Enable, we_mask[k]);
      check("t2_frame_done", frame_done, k == 12);
      if (k == 8) check("t2_resume_data", fifo_data, base + 2);
      if (k == 12) begin
        check("t2_wr_cnt", wr_cnt, 6);
        check("t2_writes", wr_seen, 6);
      end
      accept_note();
    end
    drive(1'b0);
    Afull = 1'b0;

    // ilen=0: straight to DONE for one cycle, never busy
    start_frame(0);
    check("t3_busy_start", busy, 1'b0);
    drive(1'b1);
    @(negedge clk);
    check("t3_frame_done", frame_done, 1'b1);
    check("t3_state", fsm_state, 2'd3);
    check("t3_busy", busy, 1'b0);
    check("t3_s_ready", s_ready, 1'b0);
    check("t3_we", Write_Enable, 1'b0);
    drive(1'b1);
    @(negedge clk);
    check("t3_frame_done_once", frame_done, 1'b0);
    check("t3_s_ready_after", s_ready, 1'b0);
    drive(1'b0);

    // ilen=10, clear after 4 accepts, then a normal ilen=3 frame
    start_frame(10);
    for (int k = 0; k < 4; k++) begin
      drive(1'b1);
      @(negedge clk);
      accept_note();
    end
    drive(1'b0);
    clear = 1'b1;
    @(negedge clk);
    drive(1'b0);
    clear = 1'b0;
    @(negedge clk);
    check("t4_s_ready", s_ready, 1'b0);
    check("t4_we", Write_Enable, 1'b0);
    check("t4_fifo_data", fifo_data, 0);
    check("t4_busy", busy, 1'b0);
    check("t4_frame_done", frame_done, 1'b0);
    check("t4_wr_cnt", wr_cnt, 0);
    check("t4_state", fsm_state, 2'd0);
    drive(1'b0);
    @(negedge clk);
    check("t4_no_done_later", frame_done, 1'b0);
    exp_q.delete();
    start_frame(3);
    finish_frame(3, 1'b0, "t4_restart");

    // Full blocks writes with skid non-empty; start while busy is ignored
    start_frame(4);
    drive(1'b1);
    @(negedge clk);
    accept_note();
    drive(1'b0);
    Full  = 1'b1;
    start = 1'b1;
    ilen  = 2;
    @(negedge clk);
    check("t5_we_full", Write_Enable, 1'b0);
    check("t5_busy", busy, 1'b1);
    drive(1'b0);
    Full = 1'b0;
    ilen = 9;
    @(negedge clk);
    check("t5_we_resume", Write_Enable, 1'b1);
    finish_frame(4, 1'b0, "t5");

    // random valid gaps and Afull, ilen=16
    start_frame(16);
    finish_frame(16, 1'b1, "t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/intpol2_d4_in_fifo_wr.md
INTPOL2_D4_IN_FIFO_WR -- requirements
Module: intpol2_D4_in_fifo_wr

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, sample width.
REQ-002 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous reset, active-high.
REQ-004 SHALL have port clear  input  1  synchronous soft clear, active-high.
REQ-005 SHALL have port start  input  1  one-cycle pulse that begins a frame.
REQ-006 SHALL have port ilen  input  DATA_WIDTH+1  frame length in samples, sampled on accepted start.
REQ-007 SHALL have port s_data  input  DATA_WIDTH  upstream sample.
REQ-008 SHALL have port s_valid  input  1  upstream sample valid.
REQ-009 SHALL have port s_ready  output  1  block accepts s_data this cycle.
REQ-010 SHALL have port Afull  input  1  interpolator input FIFO almost full.
REQ-011 SHALL have port Full  input  1  interpolator input FIFO full.
REQ-012 SHALL have port Write_Enable  output  1  FIFO write strobe.
REQ-013 SHALL have port fifo_data  output  DATA_WIDTH  FIFO write data, valid with Write_Enable.
REQ-014 SHALL have port busy  output  1  frame in progress.
REQ-015 SHALL have port frame_done  output  1  one-cycle pulse after last write of frame.
REQ-016 SHALL have port wr_cnt  output  DATA_WIDTH+1  samples written in current frame.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD, FLUSH, DONE.
REQ-018 IDLE: start=1 latches ilen, clears wr_cnt and accept counter; ilen=0 goes to DONE, else LOAD.
REQ-019 LOAD: s_ready = skid occupancy<2 AND accepted<ilen; handshake = s_valid AND s_ready; when accepted reaches ilen go FLUSH.
REQ-020 FLUSH: s_ready=0; stay until skid empty, then DONE.
REQ-021 DONE: frame_done=1 for exactly one cycle, busy=0 from next cycle, return to IDLE.
REQ-022 Data SHALL pass through a 2-entry skid buffer, in order; sample accepted in cycle N appears on fifo_data/Write_Enable no earlier than cycle N+1.
REQ-023 Write_Enable SHALL be 1 iff skid non-empty AND Afull=0 AND Full=0; never asserted when Full=1.
REQ-024 Accept and write in the same cycle SHALL leave occupancy unchanged; no sample lost or duplicated.
REQ-025 wr_cnt SHALL increment by 1 per Write_Enable, saturate never exceeding ilen; counters DATA_WIDTH+1 bits, no wrap within a frame.
REQ-026 busy SHALL be 1 in LOAD and FLUSH, 0 in IDLE and DONE.
REQ-027 start while busy or in DONE SHALL be ignored.
REQ-028 Afull asserted mid-frame SHALL stall writes; s_ready drops once skid holds 2; resumes next cycle after Afull=0.
REQ-029 clear SHALL act as rst (same reset values) in the cycle it is sampled, discarding skid contents; takes priority over start and handshakes.

Reset
REQ-030 On rst=1 at clk edge: state=IDLE, s_ready=0, Write_Enable=0, fifo_data=0, busy=0, frame_done=0, wr_cnt=0, skid empty.
REQ-031 rst SHALL dominate clear and all other inputs; mid-frame reset abandons frame without frame_done.

Structure
REQ-032 FSM state encoding and DATA_WIDTH default SHALL live in shared package intpol2_D4_pkg.
REQ-033 Skid buffer SHALL be sub-module intpol2_D4_skid (2 entries, in/out valid-ready, occupancy output).

Verification
REQ-034 ilen=8, s_valid=1 continuous, Afull=0 -> 8 consecutive Write_Enable pulses with data in order, first one cycle after first accept, frame_done one cycle after 8th write, wr_cnt=8.
REQ-035 ilen=6, Afull=1 for cycles 3-7 of frame -> no Write_Enable during Afull, s_ready=0 once 2 held, all 6 samples written in order, none dropped.
REQ-036 ilen=0, start pulse -> no s_ready, no Write_Enable, frame_done exactly one cycle later, busy stays 0.
REQ-037 ilen=10, clear after 4 accepts -> all outputs at reset values next cycle, no frame_done, subsequent start ilen=3 completes normally with wr_cnt=3.
REQ-038 Full=1 with Afull=0 and skid non-empty -> Write_Enable=0; start asserted during busy -> ignored, ilen latch unchanged.
REQ-039 Random s_valid gaps, ilen=16 -> exactly 16 writes, data sequence identical to accepted sequence.
